// File: rtl/delay_pkg.sv
// Shared constants and FSM state type for the delay-line load scheduler.
package delay_pkg;

    localparam int DLY_W        = 10;
    localparam int SETTLE       = 64;
    localparam int CORE_SEQ_LEN = 64;   // delay core set-to-idle length; SETTLE must not go below it

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first active request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    int               j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            jj = IDX_W'(j);
            if (!found && req[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                gnt_idx = jj;
            end
        end
    end

endmodule

// File: rtl/delay_sched.sv
// Serialises per-requester delay-word loads into a single delay core, with a
// fixed settle window after each load strobe before acknowledging the requester.
//
// state | meaning
// IDLE  | waiting for any req; grants round-robin and latches sel/d
// ISSUE | set strobe high for one cycle
// WAIT  | settle window of SETTLE cycles while the core sequences
// DONE  | ack to granted requester, commit to dly_a/dly_b, advance rr_ptr
module delay_sched
    import delay_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int DLY_W  = delay_pkg::DLY_W,
    parameter  int SETTLE = delay_pkg::SETTLE,
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_sel,
    input  logic [NREQ*DLY_W-1:0] req_d,
    output logic [NREQ-1:0]       ack,
    output logic                  set,
    output logic                  sel,
    output logic [DLY_W-1:0]      d,
    output logic                  busy,
    output logic [IDX_W-1:0]      gnt_idx,
    output logic [DLY_W-1:0]      dly_a,
    output logic [DLY_W-1:0]      dly_b
);

    localparam int CNT_W = $clog2(SETTLE + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              set_q, set_d;
    logic              sel_q, sel_d;
    logic [DLY_W-1:0]  d_q, d_d;
    logic              busy_q, busy_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [DLY_W-1:0]  dly_a_q, dly_a_d;
    logic [DLY_W-1:0]  dly_b_q, dly_b_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic              any_req;
    logic              wait_last;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign any_req   = |req;
    assign wait_last = (cnt_q == CNT_W'(SETTLE - 1));

    always_ff @(posedge clk or posedge res) begin
        if (res) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (wait_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is computed one cycle ahead so it is registered in the state it belongs to.
    always_comb begin
        set_d     = 1'b0;
        ack_d     = '0;
        busy_d    = (state_d != IDLE);
        sel_d     = sel_q;
        d_d       = d_q;
        gnt_idx_d = gnt_idx_q;
        dly_a_d   = dly_a_q;
        dly_b_d   = dly_b_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    set_d     = 1'b1;
                    gnt_idx_d = arb_idx;
                    sel_d     = |(req_sel & arb_gnt);
                    d_d       = req_d[int'(arb_idx)*DLY_W +: DLY_W];
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (wait_last) begin
                    ack_d = NREQ'(1) << gnt_idx_q;
                    if (sel_q) dly_b_d = d_q;
                    else       dly_a_d = d_q;
                end
            end
            DONE: begin
                if (int'(gnt_idx_q) == NREQ - 1) rr_ptr_d = '0;
                else                             rr_ptr_d = gnt_idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            ack_q     <= '0;
            set_q     <= 1'b0;
            sel_q     <= 1'b0;
            d_q       <= '0;
            busy_q    <= 1'b0;
            gnt_idx_q <= '0;
            dly_a_q   <= '0;
            dly_b_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            ack_q     <= ack_d;
            set_q     <= set_d;
            sel_q     <= sel_d;
            d_q       <= d_d;
            busy_q    <= busy_d;
            gnt_idx_q <= gnt_idx_d;
            dly_a_q   <= dly_a_d;
            dly_b_q   <= dly_b_d;
        end
    end

    assign ack     = ack_q;
    assign set     = set_q;
    assign sel     = sel_q;
    assign d       = d_q;
    assign busy    = busy_q;
    assign gnt_idx = gnt_idx_q;
    assign dly_a   = dly_a_q;
    assign dly_b   = dly_b_q;

endmodule

// File: tb/tb_delay_sched.sv
// Scenario bench for delay_sched: a round-robin model predicts each grant at
// request time into a scoreboard, which is popped and compared on every ack.
module tb_delay_sched;

    localparam int NREQ   = 4;
    localparam int DLY_W  = 10;
    localparam int SETTLE = 64;
    localparam int GAP    = SETTLE + 3;

    typedef struct {
        int               idx;
        logic             sel;
        logic [DLY_W-1:0] d;
    } exp_t;

    logic                  clk;
    logic                  res;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_sel;
    logic [NREQ*DLY_W-1:0] req_d;
    logic [NREQ-1:0]       ack;
    logic                  set;
    logic                  sel;
    logic [DLY_W-1:0]      d;
    logic                  busy;
    logic [1:0]            gnt_idx;
    logic [DLY_W-1:0]      dly_a;
    logic [DLY_W-1:0]      dly_b;

    int               total = 0;
    int               bad   = 0;
    int               cyc   = 0;
    int               ack_cnt = 0;
    int               set_cyc_q[$];
    logic             set_sel_last;
    logic [DLY_W-1:0] set_d_last;
    exp_t             sb_q[$];
    int               model_ptr = 0;
    logic [DLY_W-1:0] exp_a = '0;
    logic [DLY_W-1:0] exp_b = '0;

    delay_sched #(.NREQ(NREQ), .DLY_W(DLY_W), .SETTLE(SETTLE)) dut (
        .clk     (clk),
        .res     (res),
        .req     (req),
        .req_sel (req_sel),
        .req_d   (req_d),
        .ack     (ack),
        .set     (set),
        .sel     (sel),
        .d       (d),
        .busy    (busy),
        .gnt_idx (gnt_idx),
        .dly_a   (dly_a),
        .dly_b   (dly_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!res && set) begin
            set_cyc_q.push_back(cyc);
            set_sel_last = sel;
            set_d_last   = d;
        end
        if (!res && ack != '0) ack_cnt++;
    end

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (ptr + k) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic do_reset();
        res = 1'b1;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;
        model_ptr = 0;
        exp_a = '0;
        exp_b = '0;
        sb_q.delete();
        set_cyc_q.delete();
    endtask

    task automatic drive(input int i, input logic s, input logic [DLY_W-1:0] dv);
        req_sel[i]             = s;
        req_d[i*DLY_W +: DLY_W] = dv;
        req[i]                 = 1'b1;
    endtask

    task automatic expect_grant();
        exp_t e;
        int   w;
        w = pick(req, model_ptr);
        e.idx = w;
        e.sel = (w >= 0) ? req_sel[w] : 1'b0;
        e.d   = (w >= 0) ? req_d[w*DLY_W +: DLY_W] : '0;
        sb_q.push_back(e);
    endtask

    // Waits for the next ack, pops the prediction, advances the model, and
    // returns one cycle later (the IDLE cycle) so the requester can drop req.
    task automatic collect(output exp_t e, output logic [NREQ-1:0] a, output int c,
                           output logic [1:0] gi, output bit to);
        to = 1'b1; a = '0; c = -1; gi = '0;
        for (int i = 0; i < 3*GAP; i++) begin
            @(negedge clk);
            if (ack !== '0) begin
                a = ack; c = cyc; gi = gnt_idx; to = 1'b0;
                break;
            end
        end
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else begin e.idx = -1; e.sel = 1'b0; e.d = '0; end
        if (!to && e.idx >= 0) begin
            model_ptr = (e.idx + 1) % NREQ;
            if (e.sel) exp_b = e.d;
            else       exp_a = e.d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if ({ack, set, sel, busy, gnt_idx} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl got ack=%b set=%b sel=%b busy=%b gnt=%0d want all 0",
                     ack, set, sel, busy, gnt_idx);
        end
        total++;
        if ({d, dly_a, dly_b} !== '0) begin
            bad++;
            $display("FAIL reset_data got d=%h a=%h b=%h want 0", d, dly_a, dly_b);
        end
        do_reset();
    endtask

    task automatic test_single();
        exp_t e; logic [NREQ-1:0] a; int c, c0; logic [1:0] gi; bit to;
        do_reset();
        c0 = cyc;
        drive(2, 1'b1, 10'h155);
        expect_grant();
        collect(e, a, c, gi, to);
        req[2] = 1'b0;
        total++;
        if (to || a !== (4'b0001 << e.idx) || gi !== 2'(e.idx) || e.idx != 2) begin
            bad++;
            $display("FAIL single_ack got ack=%b gnt=%0d to=%0d want idx 2", a, gi, to);
        end
        total++;
        if (c != c0 + SETTLE + 2) begin
            bad++;
            $display("FAIL single_ack_cycle got %0d want %0d", c - c0, SETTLE + 2);
        end
        total++;
        if (set_cyc_q.size() != 1 || set_cyc_q[0] != c0 + 1) begin
            bad++;
            $display("FAIL single_set_cycle got n=%0d first=%0d want one at 1", set_cyc_q.size(),
                     (set_cyc_q.size() > 0) ? set_cyc_q[0] - c0 : -1);
        end
        total++;
        if (set_sel_last !== e.sel || set_d_last !== e.d) begin
            bad++;
            $display("FAIL single_set_data got sel=%b d=%h want sel=%b d=%h",
                     set_sel_last, set_d_last, e.sel, e.d);
        end
        total++;
        if (dly_a !== exp_a || dly_b !== exp_b) begin
            bad++;
            $display("FAIL single_commit got a=%h b=%h want a=%h b=%h", dly_a, dly_b, exp_a, exp_b);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL single_idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_contention();
        exp_t e; logic [NREQ-1:0] a; int c, c0; logic [1:0] gi; bit to;
        do_reset();
        c0 = cyc;
        drive(0, 1'b0, 10'h101);
        drive(1, 1'b1, 10'h202);
        drive(2, 1'b0, 10'h303);
        drive(3, 1'b1, 10'h0C4);
        for (int n = 0; n < NREQ; n++) begin
            expect_grant();
            collect(e, a, c, gi, to);
            if (e.idx >= 0) req[e.idx] = 1'b0;
            total++;
            if (to || a !== (4'b0001 << e.idx) || gi !== 2'(e.idx) || e.idx != n) begin
                bad++;
                $display("FAIL contend_order n=%0d got ack=%b gnt=%0d want idx %0d", n, a, gi, n);
            end
        end
        total++;
        if (set_cyc_q.size() != NREQ || set_cyc_q[0] != c0 + 1) begin
            bad++;
            $display("FAIL contend_set_count got %0d want %0d", set_cyc_q.size(), NREQ);
        end
        for (int n = 1; n < set_cyc_q.size(); n++) begin
            total++;
            if (set_cyc_q[n] - set_cyc_q[n-1] != GAP) begin
                bad++;
                $display("FAIL contend_set_gap got %0d want %0d", set_cyc_q[n] - set_cyc_q[n-1], GAP);
            end
        end
        total++;
        if (dly_a !== exp_a || dly_b !== exp_b) begin
            bad++;
            $display("FAIL contend_commit got a=%h b=%h want a=%h b=%h", dly_a, dly_b, exp_a, exp_b);
        end
    endtask

    task automatic test_rotation();
        exp_t e; logic [NREQ-1:0] a; int c; logic [1:0] gi; bit to;
        drive(0, 1'b1, 10'h011);
        drive(3, 1'b0, 10'h3A3);
        expect_grant();
        collect(e, a, c, gi, to);
        req[0] = 1'b0;
        total++;
        if (to || a !== 4'b0001 || gi !== 2'd0) begin
            bad++;
            $display("FAIL rot_after3 got ack=%b gnt=%0d want idx 0", a, gi);
        end
        drive(0, 1'b1, 10'h022);
        expect_grant();
        collect(e, a, c, gi, to);
        req = '0;
        total++;
        if (to || a !== 4'b1000 || gi !== 2'd3 || e.idx != 3) begin
            bad++;
            $display("FAIL rot_after0 got ack=%b gnt=%0d want idx 3", a, gi);
        end
        total++;
        if (dly_a !== exp_a || dly_b !== exp_b) begin
            bad++;
            $display("FAIL rot_commit got a=%h b=%h want a=%h b=%h", dly_a, dly_b, exp_a, exp_b);
        end
    endtask

    task automatic test_late_change();
        exp_t e; logic [NREQ-1:0] a; int c; logic [1:0] gi; bit to;
        drive(0, 1'b0, 10'h0AA);
        expect_grant();
        repeat (12) @(posedge clk);
        #1;
        req_sel[0] = 1'b1;
        req_d[0 +: DLY_W] = 10'h3FF;
        @(negedge clk);
        total++;
        if (sel !== 1'b0 || d !== 10'h0AA || busy !== 1'b1) begin
            bad++;
            $display("FAIL late_hold got sel=%b d=%h busy=%b want 0 0aa 1", sel, d, busy);
        end
        collect(e, a, c, gi, to);
        req[0] = 1'b0;
        total++;
        if (to || a !== 4'b0001 || d !== e.d || sel !== e.sel) begin
            bad++;
            $display("FAIL late_ack got ack=%b d=%h sel=%b want 0001 %h %b", a, d, sel, e.d, e.sel);
        end
        total++;
        if (dly_a !== 10'h0AA || dly_a !== exp_a || dly_b !== exp_b) begin
            bad++;
            $display("FAIL late_commit got a=%h b=%h want a=0aa b=%h", dly_a, dly_b, exp_b);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e; logic [NREQ-1:0] a; int c, acks0; logic [1:0] gi; bit to;
        drive(1, 1'b0, 10'h111);
        repeat (22) @(posedge clk);
        #3 res = 1'b1;
        #1;
        total++;
        if ({set, ack, busy, sel, gnt_idx} !== '0 || d !== '0) begin
            bad++;
            $display("FAIL midrst_ctrl got set=%b ack=%b busy=%b sel=%b gnt=%0d d=%h want 0",
                     set, ack, busy, sel, gnt_idx, d);
        end
        total++;
        if (dly_a !== '0 || dly_b !== '0) begin
            bad++;
            $display("FAIL midrst_dly got a=%h b=%h want 0", dly_a, dly_b);
        end
        @(posedge clk);
        #1 res = 1'b0;
        req = '0;
        model_ptr = 0; exp_a = '0; exp_b = '0;
        acks0 = ack_cnt;
        repeat (GAP + 10) @(posedge clk);
        #1;
        total++;
        if (ack_cnt != acks0) begin
            bad++;
            $display("FAIL midrst_noack got %0d acks want 0", ack_cnt - acks0);
        end
        drive(0, 1'b0, 10'h2C3);
        drive(3, 1'b1, 10'h0F0);
        expect_grant();
        collect(e, a, c, gi, to);
        req[0] = 1'b0;
        total++;
        if (to || a !== 4'b0001 || gi !== 2'd0) begin
            bad++;
            $display("FAIL midrst_first got ack=%b gnt=%0d want idx 0", a, gi);
        end
        expect_grant();
        collect(e, a, c, gi, to);
        req[3] = 1'b0;
        total++;
        if (to || a !== (4'b0001 << e.idx) || dly_a !== exp_a || dly_b !== exp_b) begin
            bad++;
            $display("FAIL midrst_fresh got ack=%b a=%h b=%h want a=%h b=%h",
                     a, dly_a, dly_b, exp_a, exp_b);
        end
    endtask

    task automatic test_early_drop();
        exp_t e; logic [NREQ-1:0] a; int c, c0; logic [1:0] gi; bit to;
        c0 = cyc;
        drive(1, 1'b1, 10'h1E1);
        expect_grant();
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        total++;
        if (set !== 1'b1) begin
            bad++;
            $display("FAIL drop_issue got set=%b want 1", set);
        end
        collect(e, a, c, gi, to);
        total++;
        if (to || a !== 4'b0010 || c != c0 + SETTLE + 2) begin
            bad++;
            $display("FAIL drop_ack got ack=%b cycle=%0d want 0010 at %0d", a, c - c0, SETTLE + 2);
        end
        total++;
        if (dly_b !== exp_b || dly_b !== 10'h1E1) begin
            bad++;
            $display("FAIL drop_commit got b=%h want 1e1", dly_b);
        end
    endtask

    initial begin
        res = 1'b1; req = '0; req_sel = '0; req_d = '0;
        test_reset();
        test_single();
        test_contention();
        test_rotation();
        test_late_change();
        test_mid_reset();
        test_early_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/delay_sched.md
DELAY_SCHED -- requirements
Module: delay_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NREQ, 4, number of requesters.
- DLY_W, 10, delay word width.
- SETTLE, 64, post-set wait in clk cycles; SHALL be at least the delay core's set-to-idle sequence length of 64.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk input 1 single clock, rising edge.
- res input 1 reset, asynchronous, active-high.
- req input NREQ per-requester level request.
- req_sel input NREQ per-requester target line, 0=A, 1=B.
- req_d input NREQ*DLY_W per-requester delay word, slice i at [i*DLY_W +: DLY_W].
- ack output NREQ one-cycle completion pulse to the granted requester.
- set output 1 one-cycle load strobe to the delay core.
- sel output 1 line select to the delay core.
- d output DLY_W delay word to the delay core.
- busy output 1 high in every state other than IDLE.
- gnt_idx output clog2(NREQ) index of the current or last grant.
- dly_a output DLY_W last value committed to line A.
- dly_b output DLY_W last value committed to line B.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-005 In IDLE with req nonzero, the block SHALL grant one requester round-robin, searching from index rr_ptr upward with wrap-around.
REQ-006 On a grant, the block SHALL latch gnt_idx, req_sel[i] into sel and req_d slice i into d, then enter ISSUE.
REQ-007 In ISSUE, set SHALL be 1 for exactly one cycle; the FSM SHALL then enter WAIT with the wait counter at 0.
REQ-008 In WAIT, the counter SHALL increment each cycle; the FSM SHALL leave WAIT after exactly SETTLE cycles and enter DONE.
REQ-009 In DONE, ack[gnt_idx] SHALL be 1 for exactly one cycle.
REQ-010 In DONE, dly_a (sel=0) or dly_b (sel=1) SHALL be updated to d.
REQ-011 In DONE, rr_ptr SHALL be set to gnt_idx+1 modulo NREQ; the FSM SHALL then return to IDLE.
REQ-012 Latency: with req seen in IDLE at cycle 0, set SHALL be high in cycle 1 and ack in cycle SETTLE+2; back-to-back grants SHALL be SETTLE+3 cycles apart.
REQ-013 Requester protocol: hold req, req_sel and req_d stable until ack; deassert req on the edge where ack is high. Changes after the grant SHALL NOT affect the write in progress.
REQ-014 A requester dropping req before ack SHALL NOT abort the sequence; ack SHALL still be issued.
REQ-015 New requests arriving in ISSUE, WAIT or DONE SHALL be held off until IDLE.
REQ-016 Simultaneous requests: the lowest index at or above rr_ptr (with wrap) SHALL win; losers SHALL be served in rotation order.
REQ-017 set SHALL never be asserted in two cycles closer than SETTLE+3 apart.
REQ-018 sel and d SHALL be stable from ISSUE through DONE.

Reset
REQ-019 While res=1, with immediate effect, the block SHALL force: state IDLE, set 0, sel 0, d 0, ack 0, busy 0, gnt_idx 0, dly_a 0, dly_b 0, rr_ptr 0, wait counter 0.
REQ-020 On reset asserted mid-sequence, the block SHALL abort the sequence with no ack and no dly_a/dly_b update; after release, the first grant SHALL start from index 0.

Structure
REQ-021 Package delay_pkg SHALL hold DLY_W, the default SETTLE and the FSM state type.
REQ-022 Grant selection SHALL be a sub-module rr_arbiter (inputs req and rr_ptr; outputs a one-hot grant and its index), purely combinational.

Verification
REQ-023 Single request: req[2]=1, req_sel[2]=1, req_d slice 2=10'h155 -> set pulse in cycle 1 with sel=1, d=10'h155; ack[2] in cycle 66; dly_b=10'h155; dly_a unchanged.
REQ-024 Contention after reset: req=4'b1111 held, each requester dropping on its own ack -> grants in order 0,1,2,3; set pulses exactly 67 cycles apart.
REQ-025 Rotation: after a grant to 3, req=4'b1001 -> next grant goes to 0; after that grant to 0, req=4'b1001 -> next grant goes to 3.
REQ-026 Late change: alter req_d[0] and req_sel[0] in cycle 10 of WAIT -> d, sel and the committed value keep the latched data.
REQ-027 Mid-operation reset: res pulsed in WAIT cycle 20 -> set, ack and busy go to 0 at once; dly_a and dly_b are 0; no ack is issued; a fresh request completes normally.
REQ-028 Early drop: req[1] deasserted during ISSUE -> ack[1] is still issued in cycle 66.
